// File: rtl/jtcontra_gfx_ctrl_if.sv
// CPU-side bus into the jtcontra_gfx_ctrl MMR bank.
// The master drives the access and the slave returns the registered read data.
interface jtcontra_gfx_ctrl_if #(
  parameter int unsigned MMR_AW = 3
);
  logic              cpu_cen;
  logic              cpu_rnw;
  logic              cfg_cs;
  logic [MMR_AW-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic [7:0]        mmr_dout;

  modport master (
    output cpu_cen, cpu_rnw, cfg_cs, cpu_addr, cpu_dout,
    input  mmr_dout
  );

  modport slave (
    input  cpu_cen, cpu_rnw, cfg_cs, cpu_addr, cpu_dout,
    output mmr_dout
  );
endinterface

// File: rtl/jtcontra_gfx_ctrl.sv
// 007121-class control block: MMR bank, scroll/layout decode and IRQ/FIRQ/NMI generation.
// Define JTCONTRA_MMR_READ_EN to read the bank back on mmr_dout; otherwise it reads 8'hFF.
module jtcontra_gfx_ctrl #(
  parameter int unsigned MMR_AW    = 3,
  parameter int unsigned HOLD_LEN  = 0,
  parameter int unsigned NMI_LINES = 32,
  parameter int unsigned FIRQ_FDIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic               LHBL,
  input  logic               LVBL,
  input  logic [8:0]         vdump,
  jtcontra_gfx_ctrl_if.slave bus,
  output logic [8:0]         hpos,
  output logic [7:0]         vpos,
  output logic [4:0]         tile_extra,
  output logic               obj_update,
  output logic               layout,
  output logic [3:0]         extra_mask,
  output logic               flip,
  output logic               cpu_irqn,
  output logic               cpu_firqn,
  output logic               cpu_nmin
);

  localparam int unsigned   NREG      = 2 ** MMR_AW;
  localparam int unsigned   CW        = (HOLD_LEN > 1) ? $clog2(HOLD_LEN + 1) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_LEN);
  localparam logic [8:0]    NMI_MASK  = 9'(NMI_LINES - 1);
  localparam logic [7:0]    FIRQ_MASK = 8'(FIRQ_FDIV - 1);

  logic [7:0] mmr [NREG];
  logic       mmr_we;
  logic       ctrl_we;

  assign mmr_we  = bus.cpu_cen & bus.cfg_cs & ~bus.cpu_rnw;
  assign ctrl_we = mmr_we && (bus.cpu_addr == MMR_AW'(7));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mmr[i] <= 8'd0;
    end else if (mmr_we) begin
      mmr[bus.cpu_addr] <= bus.cpu_dout;
    end
  end

  assign hpos       = {mmr[1][0], mmr[0]};
  assign vpos       = mmr[2];
  assign tile_extra = {mmr[3][0], mmr[4][3:0]};
  assign obj_update = mmr[3][3];
  assign layout     = mmr[3][4];
  assign extra_mask = mmr[4][7:4];
  assign flip       = mmr[7][3];

`ifdef JTCONTRA_MMR_READ_EN
  logic [7:0] rd_q;

  // A write lands on the read port together with the decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 8'd0;
    else     rd_q <= mmr_we ? bus.cpu_dout : mmr[bus.cpu_addr];
  end

  assign bus.mmr_dout = rd_q;
`else
  logic unused_mmr;

  always_comb begin
    unused_mmr = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) unused_mmr = unused_mmr ^ (^mmr[i]);
  end

  assign bus.mmr_dout = 8'hFF;
`endif

  // Blanking inputs are registered once, then compared with their previous value.
  logic       lvbl_q, lvbl_last, lhbl_q, lhbl_last;
  logic [7:0] frame_cnt;
  logic       vb_fall, hb_fall;

  assign vb_fall = ~lvbl_q & lvbl_last;
  assign hb_fall = ~lhbl_q & lhbl_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_q    <= 1'b1;
      lvbl_last <= 1'b1;
      lhbl_q    <= 1'b1;
      lhbl_last <= 1'b1;
      frame_cnt <= 8'd0;
    end else begin
      lvbl_q    <= LVBL;
      lvbl_last <= lvbl_q;
      lhbl_q    <= LHBL;
      lhbl_last <= lhbl_q;
      if (vb_fall) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Line index: 0 = IRQ, 1 = FIRQ, 2 = NMI.
  logic [2:0]    en, req, ack;
  logic [2:0]    line_n;
  logic [CW-1:0] hold_cnt [3];

  assign en     = {mmr[7][0], mmr[7][2], mmr[7][1]};
  assign req[0] = en[0] & vb_fall;
  assign req[1] = en[1] & vb_fall & ((frame_cnt & FIRQ_MASK) == 8'd0);
  assign req[2] = en[2] & hb_fall & lvbl_q & ((vdump & NMI_MASK) == 9'd0);
  assign ack    = {3{ctrl_we}} & ~{bus.cpu_dout[0], bus.cpu_dout[2], bus.cpu_dout[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_n <= 3'b111;
      for (int i = 0; i < 3; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          line_n[i]   <= 1'b1;
          hold_cnt[i] <= '0;
        end else if (req[i]) begin
          line_n[i]   <= 1'b0;
          hold_cnt[i] <= HOLD_INIT;
        end else if (pxl_cen && (HOLD_LEN != 0) && !line_n[i]) begin
          if (hold_cnt[i] == CW'(1)) line_n[i] <= 1'b1;
          hold_cnt[i] <= hold_cnt[i] - CW'(1);
        end
      end
    end
  end

  assign cpu_irqn  = line_n[0];
  assign cpu_firqn = line_n[1];
  assign cpu_nmin  = line_n[2];

endmodule

// File: tb/tb_jtcontra_gfx_ctrl.sv
// Bench for jtcontra_gfx_ctrl: decode vectors, random MMR traffic against a model,
// and hand-written interrupt timing sequences on a held (8) and an ack-only (0) instance.
module tb_jtcontra_gfx_ctrl;

  logic       clk, rst, pxl_cen, lhbl, lvbl;
  logic [8:0] vdump;

  logic [8:0] hpos;
  logic [7:0] vpos;
  logic [4:0] tile_extra;
  logic       obj_update, layout, flip;
  logic [3:0] extra_mask;
  logic       cpu_irqn, cpu_firqn, cpu_nmin;

  logic [8:0] hpos0;
  logic [7:0] vpos0;
  logic [4:0] tile_extra0;
  logic       obj_update0, layout0, flip0;
  logic [3:0] extra_mask0;
  logic       irqn0, firqn0, nmin0;

  jtcontra_gfx_ctrl_if #(.MMR_AW(3)) bus ();
  jtcontra_gfx_ctrl_if #(.MMR_AW(3)) bus0 ();

  assign bus0.cpu_cen  = bus.cpu_cen;
  assign bus0.cpu_rnw  = bus.cpu_rnw;
  assign bus0.cfg_cs   = bus.cfg_cs;
  assign bus0.cpu_addr = bus.cpu_addr;
  assign bus0.cpu_dout = bus.cpu_dout;

  jtcontra_gfx_ctrl #(.MMR_AW(3), .HOLD_LEN(8), .NMI_LINES(32), .FIRQ_FDIV(2)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(lhbl), .LVBL(lvbl), .vdump(vdump),
    .bus(bus), .hpos(hpos), .vpos(vpos), .tile_extra(tile_extra), .obj_update(obj_update),
    .layout(layout), .extra_mask(extra_mask), .flip(flip),
    .cpu_irqn(cpu_irqn), .cpu_firqn(cpu_firqn), .cpu_nmin(cpu_nmin)
  );

  jtcontra_gfx_ctrl #(.MMR_AW(3), .HOLD_LEN(0), .NMI_LINES(32), .FIRQ_FDIV(2)) dut0 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(lhbl), .LVBL(lvbl), .vdump(vdump),
    .bus(bus0), .hpos(hpos0), .vpos(vpos0), .tile_extra(tile_extra0), .obj_update(obj_update0),
    .layout(layout0), .extra_mask(extra_mask0), .flip(flip0),
    .cpu_irqn(irqn0), .cpu_firqn(firqn0), .cpu_nmin(nmin0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    pxl_cen = 1'b0;
    forever begin
      @(posedge clk);
      #1 pxl_cen = ~pxl_cen;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         total, bad;
  logic [7:0] mem [8];
  int         frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mmr_write(input logic [2:0] a, input logic [7:0] d);
    bus.cpu_cen  = 1'b1;
    bus.cfg_cs   = 1'b1;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    tick(1);
    mem[a]       = d;
    bus.cpu_cen  = 1'b0;
    bus.cfg_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
  endtask

  task automatic do_reset();
    lvbl  = 1'b1;
    lhbl  = 1'b1;
    vdump = 9'd0;
    rst   = 1'b1;
    tick(2);
    rst   = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    frames = 0;
    tick(1);
  endtask

  // Expected decode from the model bank, using plain arithmetic on register values.
  function automatic logic [28:0] model_decode();
    int h, te, ob, ly, xm, fl;
    h  = (mem[1] % 2) * 256 + mem[0];
    te = (mem[3] % 2) * 16 + mem[4] % 16;
    ob = (mem[3] / 8) % 2;
    ly = (mem[3] / 16) % 2;
    xm = mem[4] / 16;
    fl = (mem[7] / 8) % 2;
    return {9'(h), mem[2], 5'(te), 1'(ob), 1'(ly), 4'(xm), 1'(fl)};
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a);
`ifdef JTCONTRA_MMR_READ_EN
    return mem[a];
`else
    return 8'hFF + 8'(a & 3'd0);
`endif
  endfunction

  logic [28:0] dec;
  assign dec = {hpos, vpos, tile_extra, obj_update, layout, extra_mask, flip};

  // NMI falling-edge recorder
  bit         rec;
  logic [8:0] nmi_seen[$];
  int         nmi_blank;
  logic       prev_nmin;

  initial begin
    prev_nmin = 1'b1;
    nmi_blank = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rec && prev_nmin && !cpu_nmin) begin
        nmi_seen.push_back(vdump);
        if (!lvbl) nmi_blank++;
      end
      prev_nmin = cpu_nmin;
    end
  end

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         n;
    bit         seen, released, low_seen, low_seen0;
    logic [8:0] exp_lines[$];

    total = 0;
    bad   = 0;
    rec   = 0;
    bus.cpu_cen  = 1'b0;
    bus.cfg_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_addr = 3'd0;
    bus.cpu_dout = 8'd0;

    //               addr  data   {hpos, vpos, tile_extra, obj, layout, mask, flip}
    vecs[0] = '{3'd0, 8'h34, {9'h034, 8'h00, 5'h00, 1'b0, 1'b0, 4'h0, 1'b0}};
    vecs[1] = '{3'd1, 8'h01, {9'h134, 8'h00, 5'h00, 1'b0, 1'b0, 4'h0, 1'b0}};
    vecs[2] = '{3'd3, 8'h19, {9'h134, 8'h00, 5'h10, 1'b1, 1'b1, 4'h0, 1'b0}};
    vecs[3] = '{3'd4, 8'hA5, {9'h134, 8'h00, 5'h15, 1'b1, 1'b1, 4'hA, 1'b0}};
    vecs[4] = '{3'd2, 8'h7E, {9'h134, 8'h7E, 5'h15, 1'b1, 1'b1, 4'hA, 1'b0}};
    vecs[5] = '{3'd7, 8'h08, {9'h134, 8'h7E, 5'h15, 1'b1, 1'b1, 4'hA, 1'b1}};
    vecs[6] = '{3'd1, 8'hFE, {9'h034, 8'h7E, 5'h15, 1'b1, 1'b1, 4'hA, 1'b1}};

    do_reset();
    check("reset_outputs", {dec, cpu_irqn, cpu_firqn, cpu_nmin}, {29'd0, 3'b111});

    for (int i = 0; i < 7; i++) begin
      mmr_write(vecs[i].addr, vecs[i].data);
      check($sformatf("decode_vec%0d", i), 32'(dec), 32'(vecs[i].exp));
    end

    mmr_write(3'd5, 8'h5A);
    bus.cpu_addr = 3'd5;
    tick(2);
`ifdef JTCONTRA_MMR_READ_EN
    check("readback_mmr5", 32'(bus.mmr_dout), 32'h5A);
`else
    check("readback_mmr5", 32'(bus.mmr_dout), 32'hFF);
`endif

    // Random register traffic; blanking idle so no interrupts are requested.
    for (int i = 0; i < 100; i++) begin
      logic cen, cs, rnw;
      logic [2:0] a;
      logic [7:0] d;
      cen = 1'($urandom_range(0, 1));
      cs  = 1'($urandom_range(0, 1));
      rnw = 1'($urandom_range(0, 1));
      a   = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      bus.cpu_cen = cen; bus.cfg_cs = cs; bus.cpu_rnw = rnw; bus.cpu_addr = a; bus.cpu_dout = d;
      tick(1);
      if (cen && cs && !rnw) mem[a] = d;
      bus.cpu_cen = 1'b0;
      tick(1);
      check($sformatf("rand_decode%0d", i), 32'(dec), 32'(model_decode()));
      check($sformatf("rand_read%0d", i), 32'(bus.mmr_dout), 32'(model_read(a)));
    end

    // IRQ with hold, and ack-only release on the HOLD_LEN=0 instance.
    do_reset();
    mmr_write(3'd7, 8'h02);
    lvbl = 1'b0;
    tick(1);
    check("irq_latency_1clk", 32'(cpu_irqn), 32'd1);
    tick(1);
    frames++;
    check("irq_low_2clk", 32'(cpu_irqn), 32'd0);
    check("irq0_low_2clk", 32'(irqn0), 32'd0);
    n = 0;
    released = 0;
    for (int k = 0; k < 100 && !released; k++) begin
      @(posedge clk);
      if (pxl_cen) n++;
      #1;
      if (cpu_irqn) released = 1;
    end
    check("irq_released", 32'(released), 32'd1);
    check("irq_hold_ticks", 32'(n), 32'd8);
    lvbl = 1'b1;
    tick(20);
    check("irq0_still_low", 32'(irqn0), 32'd0);
    mmr_write(3'd7, 8'h00);
    check("irq0_ack_release", 32'(irqn0), 32'd1);

    // FIRQ every second frame, counted from frame 0.
    do_reset();
    mmr_write(3'd7, 8'h04);
    for (int f = 0; f < 6; f++) begin
      bit exp_pulse;
      exp_pulse = (frames % 2 == 0);
      lvbl = 1'b0;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        tick(1);
        if (!cpu_firqn) seen = 1;
      end
      frames++;
      lvbl = 1'b1;
      tick(10);
      check($sformatf("firq_frame%0d", f), 32'(seen), 32'(exp_pulse));
    end

    // Ack and request land on the same clk: the ack wins.
    if (frames % 2 != 0) begin
      mmr_write(3'd7, 8'h00);
      lvbl = 1'b0; tick(3); frames++;
      lvbl = 1'b1; tick(3);
    end
    mmr_write(3'd7, 8'h00);
    mmr_write(3'd7, 8'h04);
    check("firq0_pre_collision", 32'(firqn0), 32'd1);
    lvbl = 1'b0;
    tick(1);
    bus.cpu_cen = 1'b1; bus.cfg_cs = 1'b1; bus.cpu_rnw = 1'b0;
    bus.cpu_addr = 3'd7; bus.cpu_dout = 8'h00;
    tick(1);
    mem[7] = 8'h00;
    bus.cpu_cen = 1'b0; bus.cfg_cs = 1'b0; bus.cpu_rnw = 1'b1;
    frames++;
    low_seen = 0;
    low_seen0 = 0;
    for (int k = 0; k < 6; k++) begin
      if (!cpu_firqn) low_seen = 1;
      if (!firqn0) low_seen0 = 1;
      tick(1);
    end
    check("firq_ack_wins", 32'(low_seen), 32'd0);
    check("firq0_ack_wins", 32'(low_seen0), 32'd0);
    lvbl = 1'b1;
    tick(2);

    // NMI cadence over a full 264-line frame, active video on lines 16..239.
    do_reset();
    mmr_write(3'd7, 8'h01);
    nmi_seen.delete();
    nmi_blank = 0;
    rec = 1;
    for (int v = 0; v < 264; v++) begin
      vdump = 9'(v);
      lvbl  = (v >= 16 && v < 240);
      lhbl  = 1'b1;
      tick(4);
      lhbl  = 1'b0;
      tick(4);
    end
    lhbl = 1'b1;
    lvbl = 1'b1;
    tick(20);
    rec = 0;
    for (int v = 0; v < 264; v++)
      if (v % 32 == 0 && v >= 16 && v < 240) exp_lines.push_back(9'(v));
    check("nmi_count", 32'(nmi_seen.size()), 32'(exp_lines.size()));
    check("nmi_in_blank", 32'(nmi_blank), 32'd0);
    for (int i = 0; i < exp_lines.size() && i < nmi_seen.size(); i++)
      check($sformatf("nmi_line%0d", i), 32'(nmi_seen[i]), 32'(exp_lines[i]));

    // Asynchronous reset with all three lines asserted.
    do_reset();
    mmr_write(3'd0, 8'h34);
    mmr_write(3'd7, 8'h07);
    vdump = 9'd64;
    lhbl  = 1'b0;
    tick(1);
    lvbl  = 1'b0;
    tick(3);
    check("all_lines_low", 32'({cpu_irqn, cpu_firqn, cpu_nmin}), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {dec, cpu_irqn, cpu_firqn, cpu_nmin}, {29'd0, 3'b111});
    check("rst_async_lines0", 32'({irqn0, firqn0, nmin0}), 32'd7);
    check("rst_frame_cnt", 32'(dut.frame_cnt), 32'd0);
    lvbl = 1'b1;
    lhbl = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
